// File: rtl/fifo_tx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_tx_pkg
//
// Shared definitions for the FIFO drain serializer:
//   - tx_state_e : serializer FSM states
//   - DATA_BITS  : width of one FIFO word / serial payload
//   - COUNT_W    : width of the completed-frame counter
// -----------------------------------------------------------------------------
package fifo_tx_pkg;

    localparam int DATA_BITS = 16;
    localparam int COUNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_e;

endpackage

// File: rtl/fifo_tx_serializer_bit_timer.sv
// -----------------------------------------------------------------------------
// ser_bit_timer
//
// Bit timing for the serializer.
//   clk       in   clock, rising edge
//   resetn    in   asynchronous active-low reset
//   restart   in   hold both counters at zero (frame not in progress)
//   data_adv  in   advance the data-bit counter on each bit_end
//   bit_end   out  last clock of the current bit time
//   last_bit  out  data-bit counter is on bit 15
// -----------------------------------------------------------------------------
module ser_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    input  logic data_adv,
    output logic bit_end,
    output logic last_bit
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       bit_q;
    logic [3:0]       bit_d;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign last_bit = (bit_q == 4'd15);

    // The clock counter reloads at every bit boundary, so each bit of the
    // frame lasts exactly CLKS_PER_BIT cycles with no gaps between bits.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || bit_end) begin
            cnt_d = '0;
        end
    end

    // Data-bit index; wraps 15 -> 0 on the last data bit, which is also
    // the point where the FSM leaves DATA.
    always_comb begin
        bit_d = bit_q;
        if (restart) begin
            bit_d = 4'd0;
        end else if (data_adv && bit_end) begin
            bit_d = bit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            bit_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/fifo_tx_serializer.sv
// -----------------------------------------------------------------------------
// fifo_tx_serializer
//
// Drains the 8x16 FIFO onto a UART-style serial line. Each popped word is
// sent MSB first as: start (0), 16 data bits, optional parity, stop (1).
//
// Ports:
//   clk          in   clock, rising edge
//   resetn       in   asynchronous active-low reset
//   enable       in   allow a new frame to start (looked at in IDLE only)
//   f_empty      in   FIFO empty flag (looked at in IDLE only)
//   rd_en        out  FIFO read strobe, one cycle per frame
//   rd_data[15:0] in  FIFO read data, valid the cycle after rd_en
//   tx           out  serial line, idle high
//   busy         out  high whenever a frame is in progress
//   frame_count[7:0] out  completed frames, wraps
//   dbg_state[2:0]   out  current FSM state (tx_state_e encoding)
//
// Handshake: the FIFO is read by a single-cycle rd_en pulse; the word is
// taken one cycle later. This block is the only reader, so a non-empty flag
// seen in IDLE guarantees the word is still there when rd_en fires.
// -----------------------------------------------------------------------------
module fifo_tx_serializer
    import fifo_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 f_empty,
    output logic                 rd_en,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 tx,
    output logic                 busy,
    output logic [COUNT_W-1:0]   frame_count,
    output logic [2:0]           dbg_state
);

    tx_state_e            state_q;
    tx_state_e            state_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic                 parity_q;
    logic                 parity_d;
    logic                 tx_q;
    logic                 tx_d;
    logic                 busy_q;
    logic                 busy_d;
    logic [COUNT_W-1:0]   fcnt_q;
    logic [COUNT_W-1:0]   fcnt_d;

    logic                 restart;
    logic                 data_adv;
    logic                 bit_end;
    logic                 last_bit;

    // Timers run only while a frame is on the line; POP and LOAD hold them
    // at zero so the first START cycle begins a full bit time.
    assign restart  = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);
    assign data_adv = (state_q == DATA);

    ser_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .resetn   (resetn),
        .restart  (restart),
        .data_adv (data_adv),
        .bit_end  (bit_end),
        .last_bit (last_bit)
    );

    // Next-state, shift register, parity and frame counter.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        fcnt_d   = fcnt_q;

        case (state_q)
            IDLE: begin
                if (enable && !f_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d  = rd_data;
                parity_d = (^rd_data) ^ PARITY_ODD;
                state_d  = START;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = {shreg_q[DATA_BITS-2:0], 1'b0};
                    if (last_bit) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    fcnt_d  = fcnt_q + COUNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx and busy are registered from the next state so they switch on the
    // same edge as the state itself. In DATA the line carries the MSB of the
    // already-shifted register, so the new bit appears with the bit boundary.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[DATA_BITS-1];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Decoded straight from the state register: a clean one-cycle pulse.
    assign rd_en       = (state_q == POP);
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frame_count = fcnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_tx_serializer
//
// Four serializer instances share clk/resetn:
//   0: 4 clocks/bit, even parity   1: 4 clocks/bit, odd parity
//   2: 4 clocks/bit, no parity     3: 1 clock/bit, even parity
// Each has its own FIFO model. Expected line waveforms are built from the
// frame format: two idle-high cycles (pop, load), then start, data MSB first,
// optional parity, stop, every bit held for the instance's bit time.
// -----------------------------------------------------------------------------
module tb_fifo_tx_serializer;

  localparam int NI = 4;

  logic clk;
  logic resetn;
  int   cyc = 0;

  logic        en   [NI];
  logic        emp  [NI];
  logic [15:0] rdd  [NI];
  logic        rde  [NI];
  logic        txs  [NI];
  logic        bsy  [NI];
  logic [7:0]  fc   [NI];
  logic [2:0]  dbg  [NI];

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  fifo_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .enable(en[0]), .f_empty(emp[0]), .rd_en(rde[0]),
    .rd_data(rdd[0]), .tx(txs[0]), .busy(bsy[0]), .frame_count(fc[0]), .dbg_state(dbg[0]));
  fifo_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .enable(en[1]), .f_empty(emp[1]), .rd_en(rde[1]),
    .rd_data(rdd[1]), .tx(txs[1]), .busy(bsy[1]), .frame_count(fc[1]), .dbg_state(dbg[1]));
  fifo_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut2 (
    .clk(clk), .resetn(resetn), .enable(en[2]), .f_empty(emp[2]), .rd_en(rde[2]),
    .rd_data(rdd[2]), .tx(txs[2]), .busy(bsy[2]), .frame_count(fc[2]), .dbg_state(dbg[2]));
  fifo_tx_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut3 (
    .clk(clk), .resetn(resetn), .enable(en[3]), .f_empty(emp[3]), .rd_en(rde[3]),
    .rd_data(rdd[3]), .tx(txs[3]), .busy(bsy[3]), .frame_count(fc[3]), .dbg_state(dbg[3]));

  function automatic int c_of(input int k);
    return (k == 3) ? 1 : 4;
  endfunction
  function automatic bit pen_of(input int k);
    return (k == 2) ? 1'b0 : 1'b1;
  endfunction
  function automatic bit odd_of(input int k);
    return (k == 1) ? 1'b1 : 1'b0;
  endfunction

  // ---------------- FIFO models (registered read data) ----------------
  logic [15:0] mem [NI][512];
  int          wp  [NI];
  int          rp  [NI];
  int          rd_cnt [NI];
  bit          underrun [NI];
  int          exp_fc [NI];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rde[k] === 1'b1) begin
        if (wp[k] == rp[k]) underrun[k] <= 1'b1;
        rdd[k]    <= mem[k][rp[k] % 512];
        rp[k]     <= rp[k] + 1;
        rd_cnt[k] <= rd_cnt[k] + 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      emp[k] = (wp[k] == rp[k]);
    end
  end

  task automatic push(input int k, input logic [15:0] w);
    mem[k][wp[k] % 512] = w;
    wp[k] = wp[k] + 1;
  endtask

  // ---------------- capture and reference model ----------------
  logic [0:0] tr_q [$];
  logic [0:0] exp_q [$];
  int         tr_rd;
  int         tr_pop_cyc;
  bit         tr_to;

  // Records tx from the rd_en cycle through the last busy cycle; returns at
  // the negedge of the first idle cycle.
  task automatic capture(input int k);
    int guard;
    tr_q.delete();
    tr_rd = 0;
    tr_to = 1'b0;
    guard = 0;
    while (rde[k] !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tr_to = 1'b1;
      return;
    end
    tr_pop_cyc = cyc;
    guard = 0;
    while (bsy[k] === 1'b1 && guard < 1000) begin
      tr_q.push_back(txs[k]);
      if (rde[k] === 1'b1) tr_rd++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) tr_to = 1'b1;
  endtask

  task automatic build_exp(input int k, input logic [15:0] w);
    logic [0:0] bits [$];
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    bits.push_back(1'b0);
    for (int i = 15; i >= 0; i--) bits.push_back(w[i]);
    if (pen_of(k)) bits.push_back((^w) ^ odd_of(k));
    bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int r = 0; r < c_of(k); r++) exp_q.push_back(bits[b]);
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (tr_q.size() < exp_q.size()) ? tr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (tr_q[i] !== exp_q[i]) return i;
    end
    if (tr_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic tr_bit(input int i);
    if (i >= 0 && i < tr_q.size()) return tr_q[i];
    return 1'bx;
  endfunction
  function automatic logic exp_bit(input int i);
    if (i >= 0 && i < exp_q.size()) return exp_q[i];
    return 1'bx;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (txs[k] !== 1'b1 || rde[k] !== 1'b0 || bsy[k] !== 1'b0 || fc[k] !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_values[%0d]: tx=%b rd_en=%b busy=%b frame_count=%0d, expected 1 0 0 0",
                 k, txs[k], rde[k], bsy[k], fc[k]);
      end
    end
  endtask

  task automatic test_single_word();
    int d;
    int r0;
    r0 = rd_cnt[0];
    push(0, 16'hA5C3);
    en[0] = 1'b1;
    capture(0);
    en[0] = 1'b0;
    build_exp(0, 16'hA5C3);
    d = first_diff();
    vectors++;
    if (tr_to || d != -1) begin
      miscompares++;
      $display("FAIL single_tx_trace: at cycle %0d tx=%b expected %b (len %0d expected %0d, timeout=%0d)",
               d, tr_bit(d), exp_bit(d), tr_q.size(), exp_q.size(), tr_to);
    end
    vectors++;
    if (tr_q.size() != 78) begin
      miscompares++;
      $display("FAIL single_busy_len: busy high %0d cycles, expected 78", tr_q.size());
    end
    vectors++;
    if (rd_cnt[0] - r0 != 1 || tr_rd != 1) begin
      miscompares++;
      $display("FAIL single_rd_pulses: %0d rd_en cycles, expected 1", rd_cnt[0] - r0);
    end
    exp_fc[0]++;
    vectors++;
    if (fc[0] !== 8'(exp_fc[0])) begin
      miscompares++;
      $display("FAIL single_frame_count: got %0d expected %0d", fc[0], exp_fc[0]);
    end
  endtask

  task automatic test_odd_parity();
    int   d;
    logic pbit;
    push(1, 16'h0001);
    en[1] = 1'b1;
    capture(1);
    en[1] = 1'b0;
    build_exp(1, 16'h0001);
    d = first_diff();
    vectors++;
    if (tr_to || d != -1) begin
      miscompares++;
      $display("FAIL odd_tx_trace: at cycle %0d tx=%b expected %b (len %0d expected %0d, timeout=%0d)",
               d, tr_bit(d), exp_bit(d), tr_q.size(), exp_q.size(), tr_to);
    end
    // Parity bit sits after pop, load, start and 16 data bits.
    pbit = tr_bit(2 + 17 * 4);
    vectors++;
    if (pbit !== 1'b0) begin
      miscompares++;
      $display("FAIL odd_parity_bit: got %b expected 0", pbit);
    end
    exp_fc[1]++;
    vectors++;
    if (fc[1] !== 8'(exp_fc[1])) begin
      miscompares++;
      $display("FAIL odd_frame_count: got %0d expected %0d", fc[1], exp_fc[1]);
    end
  endtask

  task automatic test_no_parity();
    int d;
    push(2, 16'h0001);
    en[2] = 1'b1;
    capture(2);
    en[2] = 1'b0;
    build_exp(2, 16'h0001);
    d = first_diff();
    vectors++;
    if (tr_to || d != -1) begin
      miscompares++;
      $display("FAIL nopar_tx_trace: at cycle %0d tx=%b expected %b (len %0d expected %0d, timeout=%0d)",
               d, tr_bit(d), exp_bit(d), tr_q.size(), exp_q.size(), tr_to);
    end
    vectors++;
    if (tr_q.size() - 2 != 72) begin
      miscompares++;
      $display("FAIL nopar_frame_len: frame %0d cycles, expected 72", tr_q.size() - 2);
    end
    exp_fc[2]++;
    vectors++;
    if (fc[2] !== 8'(exp_fc[2])) begin
      miscompares++;
      $display("FAIL nopar_frame_count: got %0d expected %0d", fc[2], exp_fc[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    int          pops [3];
    int          d;
    int          r0;
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    r0 = rd_cnt[0];
    for (int i = 0; i < 3; i++) push(0, words[i]);
    en[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      capture(0);
      pops[i] = tr_pop_cyc;
      build_exp(0, words[i]);
      d = first_diff();
      vectors++;
      if (tr_to || d != -1) begin
        miscompares++;
        $display("FAIL b2b_tx_trace[%0d]: at cycle %0d tx=%b expected %b (len %0d expected %0d)",
                 i, d, tr_bit(d), exp_bit(d), tr_q.size(), exp_q.size());
      end
    end
    en[0] = 1'b0;
    for (int i = 1; i < 3; i++) begin
      vectors++;
      if (pops[i] - pops[i-1] != 79) begin
        miscompares++;
        $display("FAIL b2b_period[%0d]: got %0d cycles expected 79", i, pops[i] - pops[i-1]);
      end
    end
    vectors++;
    if (rd_cnt[0] - r0 != 3) begin
      miscompares++;
      $display("FAIL b2b_rd_pulses: got %0d expected 3", rd_cnt[0] - r0);
    end
    exp_fc[0] += 3;
    vectors++;
    if (fc[0] !== 8'(exp_fc[0])) begin
      miscompares++;
      $display("FAIL b2b_frame_count: got %0d expected %0d", fc[0], exp_fc[0]);
    end
  endtask

  task automatic test_random();
    logic [15:0] w [$];
    int          k;
    int          n;
    int          d;
    for (int it = 0; it < 10; it++) begin
      k = $urandom_range(0, NI - 1);
      n = $urandom_range(1, 3);
      w.delete();
      for (int i = 0; i < n; i++) begin
        w.push_back(16'($urandom));
        push(k, w[i]);
      end
      en[k] = 1'b1;
      for (int i = 0; i < n; i++) begin
        capture(k);
        build_exp(k, w[i]);
        d = first_diff();
        exp_fc[k]++;
        vectors++;
        if (tr_to || d != -1) begin
          miscompares++;
          $display("FAIL rand_tx_trace: inst %0d word %h at cycle %0d tx=%b expected %b (len %0d expected %0d)",
                   k, w[i], d, tr_bit(d), exp_bit(d), tr_q.size(), exp_q.size());
        end
        vectors++;
        if (fc[k] !== 8'(exp_fc[k])) begin
          miscompares++;
          $display("FAIL rand_frame_count: inst %0d got %0d expected %0d", k, fc[k], exp_fc[k]);
        end
      end
      en[k] = 1'b0;
    end
  endtask

  task automatic test_enable_low();
    int r0;
    int lows;
    r0 = rd_cnt[0];
    lows = 0;
    en[0] = 1'b0;
    push(0, 16'hBEEF);
    repeat (40) begin
      @(negedge clk);
      if (txs[0] !== 1'b1 || bsy[0] !== 1'b0) lows++;
    end
    vectors++;
    if (rd_cnt[0] != r0) begin
      miscompares++;
      $display("FAIL enlow_rd_pulses: got %0d expected 0", rd_cnt[0] - r0);
    end
    vectors++;
    if (lows != 0) begin
      miscompares++;
      $display("FAIL enlow_tx_idle: %0d cycles tx low or busy, expected 0", lows);
    end
    wp[0] = rp[0];
  endtask

  task automatic test_enable_drop();
    int r0;
    int d;
    int lows;
    r0 = rd_cnt[0];
    lows = 0;
    push(0, 16'h5A3C);
    push(0, 16'hC001);
    en[0] = 1'b1;
    fork
      capture(0);
      begin
        repeat (20) @(negedge clk);
        en[0] = 1'b0;
      end
    join
    build_exp(0, 16'h5A3C);
    d = first_diff();
    vectors++;
    if (tr_to || d != -1) begin
      miscompares++;
      $display("FAIL drop_tx_trace: at cycle %0d tx=%b expected %b (len %0d expected %0d)",
               d, tr_bit(d), exp_bit(d), tr_q.size(), exp_q.size());
    end
    repeat (40) begin
      @(negedge clk);
      if (txs[0] !== 1'b1 || bsy[0] !== 1'b0) lows++;
    end
    vectors++;
    if (rd_cnt[0] - r0 != 1 || wp[0] - rp[0] != 1) begin
      miscompares++;
      $display("FAIL drop_no_new_pop: %0d pops, %0d words left, expected 1 and 1",
               rd_cnt[0] - r0, wp[0] - rp[0]);
    end
    vectors++;
    if (lows != 0) begin
      miscompares++;
      $display("FAIL drop_idle_after: %0d non-idle cycles, expected 0", lows);
    end
    exp_fc[0]++;
    vectors++;
    if (fc[0] !== 8'(exp_fc[0])) begin
      miscompares++;
      $display("FAIL drop_frame_count: got %0d expected %0d", fc[0], exp_fc[0]);
    end
    wp[0] = rp[0];
  endtask

  task automatic test_empty();
    int r0;
    r0 = rd_cnt[0];
    en[0] = 1'b1;
    repeat (40) @(negedge clk);
    en[0] = 1'b0;
    vectors++;
    if (rd_cnt[0] != r0 || underrun[0]) begin
      miscompares++;
      $display("FAIL empty_no_rd: %0d pops, underrun=%0d, expected 0 and 0", rd_cnt[0] - r0, underrun[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    int r0;
    int d;
    push(0, 16'hF00D);
    en[0] = 1'b1;
    guard = 0;
    while (rde[0] !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL rst_wait_pop: no rd_en within %0d cycles, expected one", guard);
    end
    // Pop + load + 4 start cycles puts cycle 12 in the data bits.
    repeat (12) @(negedge clk);
    resetn = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) exp_fc[k] = 0;
    vectors++;
    if (txs[0] !== 1'b1 || bsy[0] !== 1'b0 || rde[0] !== 1'b0 || fc[0] !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_async: tx=%b busy=%b rd_en=%b frame_count=%0d, expected 1 0 0 0",
               txs[0], bsy[0], rde[0], fc[0]);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    r0 = rd_cnt[0];
    repeat (20) @(negedge clk);
    vectors++;
    if (rd_cnt[0] != r0) begin
      miscompares++;
      $display("FAIL rst_empty_no_rd: %0d pops, expected 0", rd_cnt[0] - r0);
    end
    en[0] = 1'b0;
    push(0, 16'h1234);
    repeat (20) @(negedge clk);
    vectors++;
    if (rd_cnt[0] != r0) begin
      miscompares++;
      $display("FAIL rst_disabled_no_rd: %0d pops, expected 0", rd_cnt[0] - r0);
    end
    en[0] = 1'b1;
    capture(0);
    en[0] = 1'b0;
    build_exp(0, 16'h1234);
    d = first_diff();
    vectors++;
    if (tr_to || d != -1) begin
      miscompares++;
      $display("FAIL rst_post_trace: at cycle %0d tx=%b expected %b (len %0d expected %0d)",
               d, tr_bit(d), exp_bit(d), tr_q.size(), exp_q.size());
    end
    exp_fc[0]++;
    vectors++;
    if (fc[0] !== 8'(exp_fc[0])) begin
      miscompares++;
      $display("FAIL rst_frame_count: got %0d expected %0d", fc[0], exp_fc[0]);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] w [$];
    int          d;
    int          bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      w.push_back(16'($urandom));
      push(3, w[i]);
    end
    en[3] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      capture(3);
      build_exp(3, w[i]);
      d = first_diff();
      if (tr_to || d != -1) bad++;
      exp_fc[3]++;
      vectors++;
      if (fc[3] !== 8'(exp_fc[3])) begin
        miscompares++;
        $display("FAIL wrap_frame_count[%0d]: got %0d expected %0d", i, fc[3], exp_fc[3] % 256);
      end
    end
    en[3] = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL wrap_tx_traces: %0d frames differ from model, expected 0", bad);
    end
    vectors++;
    if (fc[3] !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap_to_zero: frame_count %0d after 256 frames, expected 0", fc[3]);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    resetn = 1'b0;
    for (int k = 0; k < NI; k++) begin
      en[k] = 1'b0;
      exp_fc[k] = 0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    test_single_word();
    test_odd_parity();
    test_no_parity();
    test_back_to_back();
    test_random();
    test_enable_low();
    test_enable_drop();
    test_empty();
    test_reset_mid_frame();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, expected sequence to complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_tx_serializer.md
# fifo_tx_serializer

- Downstream drain stage for the 8x16 FIFO.
- When enabled and the FIFO is non-empty, pops one 16-bit word and transmits it on a single-wire, UART-style serial line.
- Frame, MSB first: start bit, 16 data bits, optional parity bit, stop bit. Each bit lasts a programmable number of clocks.
- It is the FIFO's only reader, so the FIFO is drained at line rate.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clocks per serial bit; legal range 1..65535.
- PARITY_EN, default 1: 1 inserts a parity bit after the data bits.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- enable  in  1  allows new frames to start; sampled in IDLE only.
- f_empty  in  1  FIFO empty flag.
- rd_en  out  1  FIFO read strobe.
- rd_data  in  16  FIFO read data, registered inside the FIFO; valid the cycle after rd_en.
- tx  out  1  serial line; idle high.
- busy  out  1  high in every state except IDLE.
- frame_count  out  8  count of completed frames; wraps.

## Operation
States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: if enable=1 and f_empty=0, go to POP; otherwise stay.
- POP: one cycle. rd_en=1, decoded from registered state, so glitch-free. Always go to LOAD.
- LOAD: one cycle. Capture rd_data into a 16-bit shift register, compute the parity bit, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shreg[15]. Shift left once per bit time. After 16 bits go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = (^word) ^ PARITY_ODD for one bit time, then go to STOP.
- STOP: tx=1 for one bit time. frame_count increments on the final STOP cycle. Go to IDLE.

Bit timing and counters:
- Bit-time counter: $clog2(CLKS_PER_BIT+1) bits. Reloads on every bit boundary; the bit-end tick fires when the count reaches CLKS_PER_BIT-1.
- Data bit counter: 4 bits, counts 0..15.

Flow control and boundary rules:
- enable is ignored outside IDLE. Dropping enable mid-frame finishes the current frame; no new pop follows.
- f_empty is ignored outside IDLE. This block is the FIFO's sole reader, so a word seen in IDLE is still present in POP.
- f_empty=1 in IDLE means no rd_en, so the FIFO never underruns.
- frame_count wraps 255 -> 0 with no flag.
- Reset mid-frame: tx=1, state=IDLE, counters cleared, immediately (async). The popped word is discarded.

## Timing
- Reset values: tx=1, rd_en=0, busy=0, frame_count=0, state=IDLE, shreg=0.
- tx and busy are registered and change on the same edge as the state.
- Let cycle 0 be an IDLE cycle with enable=1 and f_empty=0:
  - cycle 1: POP, rd_en=1;
  - cycle 2: LOAD;
  - cycle 3: tx falls (first START cycle).
- Frame length N = (18 + PARITY_EN) * CLKS_PER_BIT cycles, counted from the first START cycle to the last STOP cycle.
- Back-to-back frames: at least one IDLE cycle between frames. Frame period = N + 3 cycles.
- frame_count is updated the cycle after the last STOP cycle, together with the IDLE entry.

## Structure
- Package fifo_tx_pkg holds:
  - state enum: IDLE, POP, LOAD, START, DATA, PARITY, STOP;
  - localparams DATA_BITS=16 and COUNT_W=8.
- Sub-module ser_bit_timer holds:
  - the CLKS_PER_BIT counter with `restart` input and `bit_end` output;
  - the 4-bit data-bit counter.
- The top level keeps the FSM, the shift register and parity, and the frame counter.

## Test plan
- Reset: resetn=0 mid-DATA with CLKS_PER_BIT=4 -> tx=1, busy=0, rd_en=0 in the same cycle; no rd_en until f_empty=0 and enable=1 after release.
- Single word: FIFO holds 16'hA5C3, defaults -> rd_en pulses exactly one cycle.
  - tx, 4 clocks per bit: 0, 1010010111000011, parity 0, 1.
  - busy high 78 cycles; frame_count=1.
- Odd parity, no parity: 16'h0001 with PARITY_ODD=1 -> parity bit 0. With PARITY_EN=0 -> frame 72 cycles, no parity bit.
- Back-to-back: 3 words 16'h1111, 16'h2222, 16'h3333 -> three frames in order, period 79 cycles each, frame_count=3, exactly 3 rd_en pulses.
- Flow control:
  - enable=0 with a non-empty FIFO -> no rd_en, tx=1 steady.
  - enable dropped during DATA -> frame completes, then IDLE.
  - f_empty=1 -> no rd_en ever.
- Wrap: 256 frames with CLKS_PER_BIT=1 -> frame_count returns to 0.
